fifo_reader: RTL and testbench

Read-side controller for the 16-deep, 8-bit FIFO. It drains the FIFO's read port and issues `rd` only when the read can be absorbed. It accounts for the FIFO's one-cycle read latency and its write-over-read priority, and presents the bytes on a valid/ready stream through a small registered skid buffer. It sits between the FIFO read port and any downstream consumer that can apply backpressure.

---
 rtl/fifo_reader_if.sv | 23 ++
 rtl/fifo_reader.sv | 141 ++++++++++++++
 tb/tb_fifo_reader.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_reader_if.sv
// fifo_reader_if: bundles the FIFO read-port signals and the downstream
// valid/ready byte stream seen by fifo_reader.
// master = the reader side, slave = the FIFO plus consumer side.
interface fifo_reader_if;
    logic       fifo_empty;
    logic       fifo_full;
    logic       fifo_wr;
    logic [7:0] fifo_dout;
    logic       fifo_rd;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;

    modport master (
        input  fifo_empty, fifo_full, fifo_wr, fifo_dout, m_ready,
        output fifo_rd, m_data, m_valid
    );

    modport slave (
        output fifo_empty, fifo_full, fifo_wr, fifo_dout, m_ready,
        input  fifo_rd, m_data, m_valid
    );
endinterface

// File: rtl/fifo_reader.sv
// fifo_reader: drains a 16x8 FIFO with one-cycle read latency and
// write-over-read priority, and streams the bytes out through a small
// circular skid buffer. Reads are only issued when buffer space is reserved
// for them, so the buffer never overflows and m_ready has no path to fifo_rd.
// Optional build macro: FIFO_READER_CNT_EN adds the 16-bit rd_cnt output
// counting delivered bytes (wraps at 16'hFFFF).
module fifo_reader #(
    parameter int BUF_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    fifo_reader_if.master bus,
`ifdef FIFO_READER_CNT_EN
    output logic [15:0]   rd_cnt,
`endif
    output logic          busy
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OCC_W = $clog2(BUF_DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             infl_q, infl_d;
    logic [7:0]       mem_q [BUF_DEPTH];
    logic [7:0]       mem_d [BUF_DEPTH];

    logic room;
    logic acc;
    logic push;
    logic pop;

    // Pointer advance with wrap at BUF_DEPTH (depth need not be a power of two)
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Space must cover bytes already buffered plus the one still in flight
    assign room = ({1'b0, occ_q} + {{OCC_W{1'b0}}, infl_q}) < (OCC_W + 1)'(BUF_DEPTH);

    assign bus.fifo_rd = rst & (state_q == RUN) & ~bus.fifo_empty & room;

    // An accepted FIFO write wins over our read, so that read did not happen
    assign acc  = bus.fifo_rd & ~bus.fifo_empty & ~(bus.fifo_wr & ~bus.fifo_full);
    assign push = infl_q;
    assign pop  = bus.m_valid & bus.m_ready;

    assign bus.m_valid = (occ_q != '0);
    assign bus.m_data  = mem_q[head_q];
    assign busy        = (state_q != IDLE);

    // Next-state for the control FSM, pointers, occupancy and buffer storage
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        occ_d   = occ_q;
        infl_d  = acc;
        mem_d   = mem_q;

        case (state_q)
            IDLE: if (en) state_d = RUN;
            RUN:  if (!en) state_d = STOP;
            STOP: begin
                if (en) begin
                    state_d = RUN;
                end else if ((occ_q == '0) && !infl_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            mem_d[tail_q] = bus.fifo_dout;
            tail_d        = ptr_inc(tail_q);
        end

        if (pop) begin
            head_d = ptr_inc(head_q);
        end

        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

`ifdef FIFO_READER_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Delivered-byte counter, wraps naturally at 16 bits
    always_comb begin
        cnt_d = cnt_q + {15'd0, pop};
    end

    assign rd_cnt = cnt_q;
`endif

    // All state registers, cleared by synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
            infl_q  <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
`ifdef FIFO_READER_CNT_EN
            cnt_q   <= 16'h0000;
`endif
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            infl_q  <= infl_d;
            mem_q   <= mem_d;
`ifdef FIFO_READER_CNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // A push into a full buffer means the read reservation logic is broken
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && (occ_q == OCC_W'(BUF_DEPTH))));

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: bench for fifo_reader with a behavioural 16-deep FIFO
// (write-over-read priority, one-cycle read latency) and a byte scoreboard.
// Optional build macro: FIFO_READER_CNT_EN also checks rd_cnt.
module tb_fifo_reader;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    logic busy;
`ifdef FIFO_READER_CNT_EN
    logic [15:0] rd_cnt;
`endif

    fifo_reader_if bus ();

    fifo_reader #(.BUF_DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .bus    (bus),
`ifdef FIFO_READER_CNT_EN
        .rd_cnt (rd_cnt),
`endif
        .busy   (busy)
    );

    // 10 time-unit clock
    always #5 clk = ~clk;

    logic [7:0]  fifo_model [$];
    logic [7:0]  exp_q [$];
    int          outstanding = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          cyc_s = 0;
    int          first_rd_cyc = -1;
    int          first_beat_cyc = -1;
    int          last_beat_cyc = -1;
    int          beats = 0;
    int          acc_count = 0;
    int          rd_count = 0;
    int          drop_count = 0;
    logic [15:0] cnt_model = 16'h0000;
    logic        rd_s, mvalid_s, busy_s;
    logic [7:0]  mdata_s;
    logic        stall_prev = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    // Free-running cycle index for latency measurements
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // One clock of stimulus plus the behavioural FIFO response at the edge
    task automatic applyStimulus(input logic en_i, input logic ready_i,
                                 input logic wr_i, input logic [7:0] wr_byte);
        @(negedge clk);
        en             = en_i;
        bus.m_ready    = ready_i;
        bus.fifo_wr    = wr_i;
        bus.fifo_empty = (fifo_model.size() == 0);
        bus.fifo_full  = (fifo_model.size() == 16);
        #1;
        rd_s     = bus.fifo_rd;
        mvalid_s = bus.m_valid;
        mdata_s  = bus.m_data;
        busy_s   = busy;
        cyc_s    = cyc;
        if (rd_s) begin
            rd_count++;
            if (first_rd_cyc < 0) first_rd_cyc = cyc_s;
            if (wr_i && fifo_model.size() < 16) drop_count++;
        end
        @(posedge clk);
        if (wr_i && fifo_model.size() < 16) begin
            fifo_model.push_back(wr_byte);
            exp_q.push_back(wr_byte);
        end else if (rd_s && fifo_model.size() > 0) begin
            bus.fifo_dout <= fifo_model.pop_front();
            outstanding++;
            acc_count++;
        end
    endtask

    task automatic preload(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            fifo_model.push_back(base + 8'(i));
            exp_q.push_back(base + 8'(i));
        end
    endtask

    // One-cycle reset; bytes read from the FIFO but not yet delivered are lost
    task automatic doReset();
        @(negedge clk);
        rst         = 1'b0;
        en          = 1'b0;
        bus.m_ready = 1'b0;
        bus.fifo_wr = 1'b0;
        #1;
        checkOutput("rd_in_reset", bus.fifo_rd, 0);
        @(posedge clk);
        for (int i = 0; i < outstanding; i++) void'(exp_q.pop_front());
        outstanding = 0;
        cnt_model   = 16'h0000;
        #1;
        rst = 1'b1;
    endtask

    task automatic waitIdle(input int budget);
        for (int i = 0; i < budget; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
            if (!busy_s) break;
        end
        checkOutput("idle_reached", busy_s, 0);
    endtask

    task automatic drainAll(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        end
        waitIdle(20);
        checkOutput("all_delivered", exp_q.size(), 0);
        checkOutput("none_in_flight", outstanding, 0);
    endtask

    // Monitor: scoreboard pop on every beat, plus stream-hold and counter checks
    always @(negedge clk) begin
        #2;
        if (rst === 1'b1) begin
            if (stall_prev) begin
                checkOutput("hold_valid", bus.m_valid, 1);
                checkOutput("hold_data", bus.m_data, prev_data);
            end
`ifdef FIFO_READER_CNT_EN
            checkOutput("rd_cnt", rd_cnt, cnt_model);
`endif
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL beat: got %0h, expected no beat (cycle %0d)", bus.m_data, cyc);
                end else begin
                    checkOutput("data", bus.m_data, exp_q.pop_front());
                    outstanding--;
                end
                beats++;
                cnt_model = cnt_model + 16'd1;
                if (first_beat_cyc < 0) first_beat_cyc = cyc;
                last_beat_cyc = cyc;
            end
            stall_prev = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.m_ready    = 1'b0;
        bus.fifo_wr    = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_full  = 1'b0;
        bus.fifo_dout  = 8'h00;

        // Reset values
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("reset_m_valid", mvalid_s, 0);
        checkOutput("reset_m_data", mdata_s, 0);
        checkOutput("reset_busy", busy_s, 0);
        checkOutput("reset_fifo_rd", rd_s, 0);
`ifdef FIFO_READER_CNT_EN
        checkOutput("reset_rd_cnt", rd_cnt, 0);
`endif

        // Full-rate drain of 16 bytes
        preload(16, 8'h10);
        first_rd_cyc   = -1;
        first_beat_cyc = -1;
        beats          = 0;
        for (int i = 0; i < 40 && beats < 16; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
            if (first_rd_cyc >= 0 && beats < 16) checkOutput("busy_run", busy_s, 1);
        end
        checkOutput("beats16", beats, 16);
        checkOutput("first_latency", first_beat_cyc - first_rd_cyc, 2);
        checkOutput("back_to_back", last_beat_cyc - first_beat_cyc, 15);
        drainAll(20);

        // Backpressure: read-ahead limited to buffer depth, head held stable
        preload(8, 8'h20);
        acc_count = 0;
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("readahead", acc_count, DEPTH);
        checkOutput("stall_valid", mvalid_s, 1);
        checkOutput("stall_head", mdata_s, 8'h20);
        drainAll(60);

        // Writes accepted by the FIFO suppress three reads
        preload(8, 8'h30);
        drop_count = 0;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
            applyStimulus(1'b1, 1'b1, (i >= 3 && i <= 5), 8'hA0 + 8'(i));
        end
        checkOutput("suppressed_reads", drop_count, 3);
        drainAll(20);

        // Dropping en stops reads; in-flight bytes still arrive, then IDLE
        preload(10, 8'h40);
        rd_count = 0;
        for (int i = 0; i < 20 && rd_count < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        for (int j = 0; j < 30; j++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
            if (j > 0) checkOutput("no_rd_after_en", rd_s, 0);
            if (!busy_s) break;
        end
        checkOutput("stop_idle", busy_s, 0);
        checkOutput("inflight_delivered", outstanding, 0);
        checkOutput("rest_in_fifo", fifo_model.size() > 0, 1);
        drainAll(40);

        // Reset with three bytes buffered
        preload(3, 8'h50);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("occ3_valid", mvalid_s, 1);
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("post_rst_m_valid", mvalid_s, 0);
        checkOutput("post_rst_busy", busy_s, 0);
        checkOutput("post_rst_fifo_rd", rd_s, 0);
`ifdef FIFO_READER_CNT_EN
        checkOutput("post_rst_rd_cnt", rd_cnt, 0);
`endif
        checkOutput("scoreboard_after_rst", exp_q.size(), 0);

        // Randomised traffic: enable, backpressure and competing FIFO writes
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 9) != 0), ($urandom_range(0, 2) != 0),
                          ($urandom_range(0, 3) == 0), 8'($urandom));
        end
        drainAll(200);

`ifdef FIFO_READER_CNT_EN
        // Counter over 300 deliveries, then wrap from 16'hFFFF
        doReset();
        for (int i = 0; i < 2000 && cnt_model < 16'd300; i++) begin
            applyStimulus(1'b1, 1'b1, ((i % 2) == 0) && (fifo_model.size() < 15), 8'($urandom));
        end
        drainAll(60);
        checkOutput("cnt_at_least_300", cnt_model >= 16'd300, 1);
        checkOutput("cnt_final", rd_cnt, cnt_model);
        preload(1, 8'h77);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        #3;
        force dut.cnt_q = 16'hFFFF;
        cnt_model = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.cnt_q;
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("cnt_wrap", rd_cnt, 0);
        drainAll(20);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
